// File: rtl/multi_flux_fifo_if.sv
// Bus bundle for the multi-flux FIFO channel.
// It carries the producer write port (din/write/full) and the per-flux consumer
// read port (empty/read/dout).
//
// Handshake: a word on din is taken at a posedge when write=1 and full=0.
// A word in flux f is popped at a posedge when read[f]=1 and empty[f]=0.
// Any other strobe is ignored.
interface multi_flux_fifo_if #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 18
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

    logic [WIDTH-1:0] din;
    logic             write;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic [FLUX-1:0]  empty;
    logic [FLUX-1:0]  read;

    // Producer and consumer actors drive this side.
    modport master (
        output din, write, read,
        input  full, dout, empty
    );

    // The FIFO drives this side.
    modport slave (
        input  din, write, read,
        output full, dout, empty
    );
endinterface

// File: rtl/multi_flux_fifo.sv
// Tagged multi-flux FIFO. There is one circular queue per flux.
// The producer writes through one tagged bus. Each flux is popped independently.
// dout presents the head of the lowest-index non-empty flux (first-word fall-through).
// Optional feature macro: MULTI_FLUX_FIFO_ERR_EN. When it is defined, the module
// adds a sticky err[3:0] output and assertions on the rising edge of each err bit.
module multi_flux_fifo #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 16
) (
    input  logic               clk,
    input  logic               rst,
    multi_flux_fifo_if.slave   bus
`ifdef MULTI_FLUX_FIFO_ERR_EN
    ,
    output logic [3:0]         err
`endif
);
    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem    [FLUX][DEPTH];
    logic [AW-1:0]         wr_ptr [FLUX];
    logic [AW-1:0]         rd_ptr [FLUX];
    logic [CW-1:0]         count  [FLUX];

    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] payload;
    logic                  tag_ok;
    logic                  full;
    logic [FLUX-1:0]       nonempty;
    logic [FLUX-1:0]       push;
    logic [FLUX-1:0]       pop;
    logic [TAG_WIDTH-1:0]  sel;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    assign tag     = bus.din[WIDTH-1:DATA_WIDTH];
    assign payload = bus.din[DATA_WIDTH-1:0];

    // Decode the write tag. Tags at or above FLUX name no queue, so the word is dropped.
    always_comb begin
        tag_ok = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            if (tag == TAG_WIDTH'(f)) tag_ok = 1'b1;
        end
    end

    // Compute occupancy flags. full depends only on the counts and never on din.
    always_comb begin
        full = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            nonempty[f] = (count[f] != '0);
            if (count[f] == DEPTH_C) full = 1'b1;
        end
    end

    // Qualify the strobes into per-flux push and pop enables.
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            push[f] = bus.write && !full && tag_ok && (tag == TAG_WIDTH'(f));
            pop[f]  = bus.read[f] && nonempty[f];
        end
    end

    // Pick the presented flux, which is the lowest non-empty index, and its head word.
    // The loop runs from the top index down, so the lowest non-empty index is assigned last.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (nonempty[f]) begin
                sel       = TAG_WIDTH'(f);
                sel_valid = 1'b1;
                sel_data  = mem[f][rd_ptr[f]];
            end
        end
    end

    assign bus.full  = full;
    assign bus.empty = ~nonempty;
    assign bus.dout  = sel_valid ? {sel, sel_data} : '0;

    // Update the pointers and counts. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (rst) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
            end else begin
                if (push[f]) wr_ptr[f] <= wr_ptr[f] + AW'(1);
                if (pop[f])  rd_ptr[f] <= rd_ptr[f] + AW'(1);
                case ({push[f], pop[f]})
                    2'b10:   count[f] <= count[f] + CW'(1);
                    2'b01:   count[f] <= count[f] - CW'(1);
                    default: count[f] <= count[f];
                endcase
            end
        end
    end

    // Write into storage. The contents need no reset because the counts gate visibility.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (push[f]) mem[f][wr_ptr[f]] <= payload;
        end
    end

`ifdef MULTI_FLUX_FIFO_ERR_EN
    logic [FLUX-1:0] sel_onehot;
    logic [3:0]      err_set;

    // Flag protocol misuse this cycle. err_set[3] also trips on any read when nothing is presented.
    always_comb begin
        sel_onehot = nonempty & ~(nonempty - FLUX'(1));
        err_set[0] = bus.write && full;
        err_set[1] = |(bus.read & ~nonempty);
        err_set[2] = bus.write && !full && !tag_ok;
        err_set[3] = |(bus.read & ~sel_onehot);
    end

    // Hold the error flags sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) err <= '0;
        else     err <= err | err_set;
    end

    for (genvar i = 0; i < 4; i++) begin : g_err_chk
        err_rise_chk : assert property (@(posedge clk) disable iff (rst) !$rose(err[i]));
    end
`endif
endmodule

// File: tb/tb_multi_flux_fifo.sv
// Self-checking bench for multi_flux_fifo.
// The reference model keeps one queue of payloads per flux.
module tb_multi_flux_fifo;
    localparam int FLUX  = 2;
    localparam int DW    = 18;
    localparam int DEPTH = 16;
    localparam int W     = DW + 1;
    localparam int OW    = W + FLUX + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // clock/reset
    always #5 clk = ~clk;

    multi_flux_fifo_if #(.FLUX(FLUX), .DATA_WIDTH(DW)) bus ();

`ifdef MULTI_FLUX_FIFO_ERR_EN
    logic [3:0] err;
`endif

    multi_flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MULTI_FLUX_FIFO_ERR_EN
        ,
        .err (err)
`endif
    );

    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic [OW-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    // Build the expected observation {empty, full, dout} from the model queues.
    function automatic logic [OW-1:0] model_view();
        logic [FLUX-1:0] e;
        logic            f;
        logic [W-1:0]    d;
        e = {mq1.size() == 0, mq0.size() == 0};
        f = (mq0.size() == DEPTH) || (mq1.size() == DEPTH);
        if (mq0.size() > 0)      d = {1'b0, mq0[0]};
        else if (mq1.size() > 0) d = {1'b1, mq1[0]};
        else                     d = '0;
        return {e, f, d};
    endfunction

    // Apply one clock edge to the model.
    // Pops are evaluated against the occupancy before the edge, then the write is applied.
    task automatic model_step(input logic w, input logic [W-1:0] d, input logic [1:0] r, input logic rs);
        logic          was_full;
        logic [DW-1:0] tmp;
        if (rs) begin
            mq0.delete();
            mq1.delete();
        end else begin
            was_full = (mq0.size() == DEPTH) || (mq1.size() == DEPTH);
            if (r[0] && mq0.size() > 0) tmp = mq0.pop_front();
            if (r[1] && mq1.size() > 0) tmp = mq1.pop_front();
            if (w && !was_full) begin
                if (d[W-1] == 1'b0) mq0.push_back(d[DW-1:0]);
                else                mq1.push_back(d[DW-1:0]);
            end
        end
    endtask

    // Driver: record the expected current state, then drive the inputs for the next edge.
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic [1:0] r, input logic rs);
        @(posedge clk);
        #1;
        exp_q.push_back(model_view());
        bus.write = w;
        bus.din   = d;
        bus.read  = r;
        rst       = rs;
        model_step(w, d, r, rs);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 2'b00, 1'b0);
    endtask

    task automatic wr(input logic t, input logic [DW-1:0] p);
        cycle(1'b1, {t, p}, 2'b00, 1'b0);
    endtask

    task automatic rd(input logic [1:0] r);
        cycle(1'b0, '0, r, 1'b0);
    endtask

    // Scoreboard monitor: compare the DUT outputs on the falling edge against the expected queue.
    initial begin
        logic [OW-1:0] e;
        logic [OW-1:0] g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.empty, bus.full, bus.dout};
                checks++;
                if (g === e) passed++;
                else $display("FAIL state t=%0t: empty=%b full=%b dout=%h, required empty=%b full=%b dout=%h",
                              $time, g[OW-1 -: FLUX], g[W], g[W-1:0], e[OW-1 -: FLUX], e[W], e[W-1:0]);
            end
        end
    end

    // Stimulus sequence
    initial begin
        bus.write = 1'b0;
        bus.din   = '0;
        bus.read  = '0;
        repeat (2) @(posedge clk);

        // Reset, then stay idle.
        repeat (3) idle();

        // Write to two fluxes, then pop flux 0 and flux 1.
        wr(1'b1, 18'h000AB);
        wr(1'b0, 18'h00012);
        rd(2'b01);
        rd(2'b10);
        idle();

        // Fill flux 0 to DEPTH. The extra write is dropped. Then drain flux 0.
        for (int i = 0; i < DEPTH; i++) wr(1'b0, DW'(i));
        wr(1'b0, 18'h3FFFF);
        for (int i = 0; i < DEPTH; i++) rd(2'b01);
        idle();

        // Wrap-around on flux 1: write and pop in the same cycle, so one word stays resident.
        wr(1'b1, 18'h00000);
        for (int i = 1; i <= 40; i++) cycle(1'b1, {1'b1, DW'(i)}, 2'b10, 1'b0);
        rd(2'b10);
        idle();

        // Flux 0 full: a same-cycle write is dropped while the pop proceeds.
        for (int i = 0; i < DEPTH; i++) wr(1'b0, DW'(100 + i));
        cycle(1'b1, {1'b0, 18'h3FFFF}, 2'b01, 1'b0);
        idle();
        for (int i = 0; i < DEPTH - 1; i++) rd(2'b01);
        idle();

        // Assert reset in the middle of a stream.
        for (int i = 0; i < 5; i++) wr(1'($urandom_range(0, 1)), DW'($urandom));
        cycle(1'b0, '0, 2'b00, 1'b1);
        idle();
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  {1'($urandom_range(0, 1)), DW'($urandom)},
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 199) == 0);
        end
        idle();
        idle();

        // Final report
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
